// File: rtl/lc3b_types.sv
// Shared L2 cache types: line index, tag and line payload widths.
package lc3b_types;

  typedef logic [3:0]   lc3b_l2_index;
  typedef logic [7:0]   lc3b_l2_tag;
  typedef logic [127:0] lc3b_l2_line;

  localparam int L2_LINES = 16;

endpackage

// File: rtl/l2_meta_array.sv
// Per-line tag/valid/dirty storage for the direct-mapped L2.
// Two combinational read ports (current line and next line), one write port.
// valid/dirty clear asynchronously on reset; tags are left untouched.
module l2_meta_array
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [3:0] windex,
  input  logic [7:0] wtag,
  input  logic       wvalid,
  input  logic       wdirty,
  input  logic [3:0] rindex,
  input  logic [3:0] rindex_n,
  output logic [7:0] rtag,
  output logic       rvalid,
  output logic       rdirty,
  output logic       rvalid_n
);

  lc3b_l2_tag            tag_q [L2_LINES];
  logic [L2_LINES-1:0]   valid_q;
  logic [L2_LINES-1:0]   dirty_q;

  // Tag storage: no reset, a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we) tag_q[windex] <= wtag;
  end

  // Valid/dirty bits with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[windex] <= wvalid;
      dirty_q[windex] <= wdirty;
    end
  end

  assign rtag     = tag_q[rindex];
  assign rvalid   = valid_q[rindex];
  assign rdirty   = dirty_q[rindex];
  assign rvalid_n = valid_q[rindex_n];

endmodule

// File: rtl/l2_cache_control.sv
// Direct-mapped L2 cache controller with writeback and next-line prefetch.
//
// state     | meaning
// IDLE      | waiting for an L1 read/write; latches the request
// TAG_CHECK | compare tag; hit answers L1, miss picks writeback or fill
// WRITEBACK | dirty victim line written to physical memory
// FILL      | requested line read from physical memory into the array
// PREFETCH  | line index+1 read from physical memory; L1 waits
module l2_cache_control
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [15:0]  mem_address,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic         array_write,
  output logic [3:0]   array_index,
  output logic [3:0]   array_index_n,
  output logic [127:0] array_datain,
  input  logic [127:0] array_dataout,
  input  logic [127:0] array_dataout_n
);

  typedef enum logic [2:0] {IDLE, TAG_CHECK, WRITEBACK, FILL, PREFETCH} state_t;

  state_t       state, state_next;
  lc3b_l2_tag   req_tag;
  lc3b_l2_index req_index;
  logic         req_write;
  lc3b_l2_line  req_wdata;
  logic         prefetch_pending, prefetch_set, prefetch_clr;
  logic [11:0]  pf_line;

  logic         meta_we, meta_wvalid, meta_wdirty;
  lc3b_l2_tag   meta_wtag, meta_tag;
  logic         meta_valid, meta_dirty, meta_valid_n;
  logic         hit;
  logic         unused_bits;

  l2_meta_array u_meta (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (meta_we),
    .windex   (array_index),
    .wtag     (meta_wtag),
    .wvalid   (meta_wvalid),
    .wdirty   (meta_wdirty),
    .rindex   (array_index),
    .rindex_n (array_index_n),
    .rtag     (meta_tag),
    .rvalid   (meta_valid),
    .rdirty   (meta_dirty),
    .rvalid_n (meta_valid_n)
  );

  // Next-line target; {tag,index}+1 wraps from 0xFFF to 0x000.
  assign pf_line       = {req_tag, req_index} + 12'd1;
  assign array_index_n = array_index + 4'd1;
  assign hit           = meta_valid && (meta_tag == req_tag);
  assign mem_rdata     = array_dataout;
  assign pmem_wdata    = array_dataout;
  // Offset bits and the next-line data port are not needed by the controller.
  assign unused_bits   = ^{mem_address[3:0], array_dataout_n};

  // State register and prefetch request flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      prefetch_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (prefetch_set)      prefetch_pending <= 1'b1;
      else if (prefetch_clr) prefetch_pending <= 1'b0;
    end
  end

  // Latch the L1 request when accepted; a simultaneous read+write is a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag   <= '0;
      req_index <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
    end else if (state == IDLE && (mem_read || mem_write)) begin
      req_tag   <= mem_address[15:8];
      req_index <= mem_address[7:4];
      req_write <= mem_write;
      req_wdata <= mem_wdata;
    end
  end

  // Next-state, memory handshakes and array/metadata updates.
  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {req_tag, req_index, 4'h0};
    array_write  = 1'b0;
    array_datain = pmem_rdata;
    array_index  = req_index;
    meta_we      = 1'b0;
    meta_wtag    = req_tag;
    meta_wvalid  = 1'b1;
    meta_wdirty  = 1'b0;
    prefetch_set = 1'b0;
    prefetch_clr = 1'b0;
    case (state)
      IDLE: begin
        if (mem_read || mem_write) state_next = TAG_CHECK;
      end
      TAG_CHECK: begin
        if (hit) begin
          mem_resp = 1'b1;
          if (req_write) begin
            array_write  = 1'b1;
            array_datain = req_wdata;
            meta_we      = 1'b1;
            meta_wdirty  = 1'b1;
          end
          state_next = prefetch_pending ? PREFETCH : IDLE;
        end else if (meta_valid && meta_dirty) begin
          state_next = WRITEBACK;
        end else begin
          state_next = FILL;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {meta_tag, req_index, 4'h0};
        if (pmem_resp) begin
          meta_we    = 1'b1;
          meta_wtag  = meta_tag;
          state_next = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          array_write  = 1'b1;
          meta_we      = 1'b1;
          prefetch_set = !req_write && !meta_valid_n;
          state_next   = TAG_CHECK;
        end
      end
      PREFETCH: begin
        array_index  = pf_line[3:0];
        pmem_read    = 1'b1;
        pmem_address = {pf_line, 4'h0};
        if (pmem_resp) begin
          array_write  = 1'b1;
          meta_we      = 1'b1;
          meta_wtag    = pf_line[11:4];
          prefetch_clr = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Scoreboard bench for l2_cache_control: directed requests push expected
// L1 responses and physical-memory transactions; a monitor pops and compares.
module tb_l2_cache_control;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         mem_read = 1'b0, mem_write = 1'b0;
  logic [15:0]  mem_address = '0;
  logic [127:0] mem_wdata = '0;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic         array_write;
  logic [3:0]   array_index, array_index_n;
  logic [127:0] array_datain, array_dataout, array_dataout_n;

  l2_cache_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .array_write(array_write), .array_index(array_index),
    .array_index_n(array_index_n), .array_datain(array_datain),
    .array_dataout(array_dataout), .array_dataout_n(array_dataout_n)
  );

  always #5 clk = ~clk;

  // Data array model: combinational reads, write on rising edge.
  logic [127:0] arr [16];
  assign array_dataout   = arr[array_index];
  assign array_dataout_n = arr[array_index_n];
  always @(posedge clk) if (array_write) arr[array_index] <= array_datain;

  typedef struct {
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic         chk_idxn;
    logic [3:0]   idxn;
  } pmem_exp_t;
  typedef struct {
    logic         chk;
    logic [127:0] data;
  } resp_exp_t;

  pmem_exp_t pexp_q[$];
  resp_exp_t rexp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0;
  int pmem_txns = 0;
  int last_presp_cyc = 0;
  int mem_resp_cyc = 0;
  int resp_cnt = 0;
  logic prev_act = 1'b0, act;
  pmem_exp_t pe;
  resp_exp_t re;

  localparam logic [127:0] W1 = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] W2 = 128'hdeadbeefcafef00d_1122334455667788;
  localparam logic [127:0] W3 = 128'h0f0f0f0f_a5a5a5a5_3c3c3c3c_96969696;

  function automatic logic [127:0] pat(input logic [15:0] a);
    logic [15:0] s;
    s = a ^ 16'hA5C3;
    return {8{s}};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, got, exp);
    end
  endtask

  task automatic exp_p(input logic wr, input logic [15:0] addr, input logic [127:0] wd,
                       input logic ci, input logic [3:0] idxn);
    pmem_exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wd; e.chk_idxn = ci; e.idxn = idxn;
    pexp_q.push_back(e);
  endtask

  task automatic exp_r(input logic c, input logic [127:0] d);
    resp_exp_t e;
    e.chk = c; e.data = d;
    rexp_q.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Physical memory: answers each request on its third cycle with pat(addr).
  int pcnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst_n && (pmem_read || pmem_write)) begin
        pcnt++;
        if (pcnt == 3) begin
          pmem_resp      = 1'b1;
          pmem_rdata     = pat(pmem_address);
          last_presp_cyc = cyc;
          pcnt           = 0;
        end
      end else begin
        pcnt = 0;
      end
    end
  end

  // Monitor: compare every new pmem transaction and every mem_resp.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      act = pmem_read || pmem_write;
      if (act && (!prev_act || pmem_resp)) begin
        pmem_txns++;
        chk("pmem_exclusive", 128'(pmem_read && pmem_write), 128'(0));
        if (pexp_q.size() == 0) begin
          chk("pmem_unexpected_addr", 128'(pmem_address), 128'hx_dead);
        end else begin
          pe = pexp_q.pop_front();
          chk("pmem_is_write", 128'(pmem_write), 128'(pe.wr));
          chk("pmem_address", 128'(pmem_address), 128'(pe.addr));
          if (pe.wr) chk("pmem_wdata", pmem_wdata, pe.wdata);
          if (pe.chk_idxn) chk("array_index_n", 128'(array_index_n), 128'(pe.idxn));
        end
      end
      prev_act = act;
      if (mem_resp) begin
        mem_resp_cyc = cyc;
        resp_cnt++;
        if (rexp_q.size() == 0) begin
          chk("mem_resp_unexpected", 128'(mem_resp), 128'(0));
        end else begin
          re = rexp_q.pop_front();
          if (re.chk) chk("mem_rdata", mem_rdata, re.data);
        end
      end
    end
  end

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, output int edges);
    edges = 0;
    @(negedge clk);
    mem_address = addr; mem_wdata = wd; mem_read = rd; mem_write = wr;
    while (1) begin
      @(negedge clk);
      edges++;
      if (mem_resp) break;
      if (edges > 200) begin
        checks++; failures++;
        $display("FAIL req_timeout: addr=%h actual=no mem_resp required=mem_resp", addr);
        break;
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet, n;
    quiet = 0;
    for (n = 0; n < 200 && quiet < 3; n++) begin
      @(negedge clk);
      if (!pmem_read && !pmem_write) quiet++; else quiet = 0;
    end
    if (quiet < 3) begin
      checks++; failures++;
      $display("FAIL idle_timeout: actual=pmem busy required=idle");
    end
  endtask

  int e, txn0, n;

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 128'({mem_resp, pmem_read, pmem_write, array_write}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 128'({mem_resp, pmem_read, pmem_write, array_write}), 128'(0));

    // Cold read: fill 0x1230, answer, then prefetch 0x1240.
    exp_p(1'b0, 16'h1230, '0, 1'b0, 4'd0);
    exp_p(1'b0, 16'h1240, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'h1230));
    do_req(1'b1, 1'b0, 16'h1230, '0, e);
    chk("fill_to_resp_cycles", 128'(mem_resp_cyc - last_presp_cyc), 128'(1));
    wait_idle();

    // Hit: response consumed on the second edge after the request.
    txn0 = pmem_txns;
    exp_r(1'b1, pat(16'h1230));
    do_req(1'b1, 1'b0, 16'h1230, '0, e);
    chk("hit_latency", 128'(e + 1), 128'(2));
    exp_r(1'b1, pat(16'h1240));
    do_req(1'b1, 1'b0, 16'h1240, '0, e);
    chk("prefetched_hit_latency", 128'(e + 1), 128'(2));
    exp_r(1'b0, '0);
    do_req(1'b0, 1'b1, 16'h1230, W1, e);
    exp_r(1'b1, W1);
    do_req(1'b1, 1'b0, 16'h1230, '0, e);
    exp_r(1'b0, '0);
    do_req(1'b1, 1'b1, 16'h1240, W3, e);
    exp_r(1'b1, W3);
    do_req(1'b1, 1'b0, 16'h1240, '0, e);
    wait_idle();
    chk("hits_no_pmem", 128'(pmem_txns), 128'(txn0));

    // Conflict miss on dirty line: writeback 0x1230 with W1, then fill 0x5530.
    exp_p(1'b1, 16'h1230, W1, 1'b0, 4'd0);
    exp_p(1'b0, 16'h5530, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'h5530));
    do_req(1'b1, 1'b0, 16'h5530, '0, e);
    wait_idle();

    // Write miss: fill only, no prefetch; then read back written data.
    exp_p(1'b0, 16'h7770, '0, 1'b0, 4'd0);
    exp_r(1'b0, '0);
    do_req(1'b0, 1'b1, 16'h7770, W2, e);
    wait_idle();
    exp_r(1'b1, W2);
    do_req(1'b1, 1'b0, 16'h7770, '0, e);
    wait_idle();

    // Top of address space: prefetch wraps to line 0x0000.
    exp_p(1'b0, 16'hFFF0, '0, 1'b1, 4'd0);
    exp_p(1'b0, 16'h0000, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'hFFF0));
    do_req(1'b1, 1'b0, 16'hFFF0, '0, e);
    wait_idle();
    exp_r(1'b1, pat(16'h0000));
    do_req(1'b1, 1'b0, 16'h0000, '0, e);
    wait_idle();

    // Request arriving during PREFETCH waits for the prefetch to finish.
    exp_p(1'b0, 16'h2350, '0, 1'b0, 4'd0);
    exp_p(1'b0, 16'h2360, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'h2350));
    do_req(1'b1, 1'b0, 16'h2350, '0, e);
    exp_r(1'b1, pat(16'h2360));
    do_req(1'b1, 1'b0, 16'h2360, '0, e);
    // prefetch resp -> IDLE accepts the waiting request -> TAG_CHECK answers
    chk("resp_after_prefetch", 128'(mem_resp_cyc - last_presp_cyc), 128'(2));
    wait_idle();

    // Reset in the middle of a fill abandons it and invalidates every line.
    exp_p(1'b0, 16'h3380, '0, 1'b0, 4'd0);
    @(negedge clk);
    mem_address = 16'h3380; mem_read = 1'b1;
    for (n = 0; n < 50 && !pmem_read; n++) @(negedge clk);
    chk("fill_started", 128'(pmem_read), 128'(1));
    rst_n = 1'b0; mem_read = 1'b0;
    #1;
    chk("async_reset_outputs", 128'({mem_resp, pmem_read, pmem_write, array_write}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle();

    exp_p(1'b0, 16'h1230, '0, 1'b0, 4'd0);
    exp_p(1'b0, 16'h1240, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'h1230));
    do_req(1'b1, 1'b0, 16'h1230, '0, e);
    wait_idle();
    // Former dirty line: no writeback after reset.
    exp_p(1'b0, 16'h7770, '0, 1'b0, 4'd0);
    exp_p(1'b0, 16'h7780, '0, 1'b0, 4'd0);
    exp_r(1'b1, pat(16'h7770));
    do_req(1'b1, 1'b0, 16'h7770, '0, e);
    wait_idle();

    chk("pmem_queue_drained", 128'(pexp_q.size()), 128'(0));
    chk("resp_queue_drained", 128'(rexp_q.size()), 128'(0));
    chk("resp_count", 128'(resp_cnt), 128'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: actual=still running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
